// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode/funct encodings, special instruction
// words and the fetch-stage state type.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ADDIU  = 6'h09;
  localparam logic [5:0] SLTI   = 6'h0A;
  localparam logic [5:0] SLTIU  = 6'h0B;
  localparam logic [5:0] ANDI   = 6'h0C;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LB     = 6'h20;
  localparam logic [5:0] LH     = 6'h21;
  localparam logic [5:0] LWL    = 6'h22;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] LBU    = 6'h24;
  localparam logic [5:0] LHU    = 6'h25;
  localparam logic [5:0] SW     = 6'h2B;

  localparam logic [5:0] JR     = 6'h08;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/rt_use_decode.sv
// Flags instructions whose rt field is not a source operand (or bubbles),
// so hazard detection can ignore rt for them.
module rt_use_decode
  import mips_pkg::*;
(
  input  logic       valid,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       invalid_rt
);

  always_comb begin
    invalid_rt = 1'b0;
    if (!valid) begin
      invalid_rt = 1'b1;
    end else begin
      case (op)
        J, JAL,
        ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI,
        LB, LH, LWL, LW, LBU, LHU: invalid_rt = 1'b1;
        R_TYPE:                    invalid_rt = (funct == JR);
        default:                   invalid_rt = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch and IF/ID pipeline register with halt-drain control
// and a saturating PC-stall cycle counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD,
  parameter logic [31:0] NOP_WORD  = mips_pkg::NOP_WORD
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PC_Stall,
  input  logic        IF_ID_Stall,
  input  logic        IF_ID_Flush,
  input  logic [31:0] Redirect_Target,
  output logic [31:0] IMem_Addr,
  input  logic [31:0] IMem_Data,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [5:0]  IF_ID_OP,
  output logic [5:0]  IF_ID_Funct,
  output logic [4:0]  IF_ID_RS,
  output logic [4:0]  IF_ID_RT,
  output logic        IF_ID_invalidRt,
  output logic        Halted,
  output logic [31:0] Stall_Count
);
  import mips_pkg::*;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         ifid_load;

  assign pc_plus4  = pc + 32'd4;
  assign IMem_Addr = pc;
  assign ifid_load = (state == RUN) && !IF_ID_Stall && !IF_ID_Flush;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc            <= RESET_PC;
      IF_ID_Instr   <= NOP_WORD;
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
      state         <= RUN;
      Halted        <= 1'b0;
      Stall_Count   <= '0;
    end else begin
      // A stall outranks a flush; a flush in DRAIN squashes a wrong-path halt.
      if (state == RUN) begin
        if (!PC_Stall) pc <= IF_ID_Flush ? Redirect_Target : pc_plus4;
      end else if (state == DRAIN && IF_ID_Flush && !IF_ID_Stall) begin
        pc <= Redirect_Target;
      end

      if (!IF_ID_Stall) begin
        if (ifid_load) begin
          IF_ID_Instr   <= IMem_Data;
          IF_ID_PCPlus4 <= pc_plus4;
          IF_ID_Valid   <= 1'b1;
        end else begin
          IF_ID_Instr   <= NOP_WORD;
          IF_ID_PCPlus4 <= '0;
          IF_ID_Valid   <= 1'b0;
        end
      end

      case (state)
        RUN: begin
          if (ifid_load && IMem_Data == HALT_WORD) state <= DRAIN;
        end
        DRAIN: begin
          if (!IF_ID_Stall) begin
            if (IF_ID_Flush) begin
              state <= RUN;
            end else begin
              state  <= HALTED;
              Halted <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (state == RUN && PC_Stall && Stall_Count != '1)
        Stall_Count <= Stall_Count + 32'd1;
    end
  end

  assign IF_ID_OP    = IF_ID_Instr[31:26];
  assign IF_ID_RS    = IF_ID_Instr[25:21];
  assign IF_ID_RT    = IF_ID_Instr[20:16];
  assign IF_ID_Funct = IF_ID_Instr[5:0];

  rt_use_decode u_rt_use_decode (
    .valid      (IF_ID_Valid),
    .op         (IF_ID_OP),
    .funct      (IF_ID_Funct),
    .invalid_rt (IF_ID_invalidRt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle-level reference model compared
// every cycle, plus hand-computed literal expectations at key points.
module tb_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] FILL = 32'h0109_5020;  // add $10,$8,$9

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        PC_Stall, IF_ID_Stall, IF_ID_Flush;
  logic [31:0] Redirect_Target;
  logic [31:0] IMem_Addr, IMem_Data;
  logic [31:0] IF_ID_Instr, IF_ID_PCPlus4;
  logic        IF_ID_Valid, IF_ID_invalidRt, Halted;
  logic [5:0]  IF_ID_OP, IF_ID_Funct;
  logic [4:0]  IF_ID_RS, IF_ID_RT;
  logic [31:0] Stall_Count;

  logic [31:0] mem [0:511];
  assign IMem_Data = mem[IMem_Addr[10:2]];

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 CLK = ~CLK;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(HALT),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .PC_Stall       (PC_Stall),
    .IF_ID_Stall    (IF_ID_Stall),
    .IF_ID_Flush    (IF_ID_Flush),
    .Redirect_Target(Redirect_Target),
    .IMem_Addr      (IMem_Addr),
    .IMem_Data      (IMem_Data),
    .IF_ID_Instr    (IF_ID_Instr),
    .IF_ID_PCPlus4  (IF_ID_PCPlus4),
    .IF_ID_Valid    (IF_ID_Valid),
    .IF_ID_OP       (IF_ID_OP),
    .IF_ID_Funct    (IF_ID_Funct),
    .IF_ID_RS       (IF_ID_RS),
    .IF_ID_RT       (IF_ID_RT),
    .IF_ID_invalidRt(IF_ID_invalidRt),
    .Halted         (Halted),
    .Stall_Count    (Stall_Count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_invalid_rt(input logic v, input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (!v) return 1'b1;
    if (op == 6'h02 || op == 6'h03) return 1'b1;
    if (op >= 6'h08 && op <= 6'h0F) return 1'b1;
    if (op >= 6'h20 && op <= 6'h25) return 1'b1;
    if (op == 6'h00 && ins[5:0] == 6'h08) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: halt_pending = a halt sits in IF/ID waiting to move on.
  logic [31:0] m_pc, m_instr, m_pcp4, m_stalls, fetched;
  logic        m_valid, m_halt_pending, m_halted, live;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      m_halt_pending = 1'b0; m_halted = 1'b0; m_stalls = 32'h0;
    end else begin
      live    = !m_halt_pending && !m_halted;
      fetched = mem[m_pc[10:2]];
      if (PC_Stall && live && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (!IF_ID_Stall) begin
        if (live && !IF_ID_Flush) begin
          m_instr = fetched; m_pcp4 = m_pc + 4; m_valid = 1'b1;
        end else begin
          m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
        end
      end
      if (live) begin
        if (!PC_Stall) m_pc = IF_ID_Flush ? Redirect_Target : m_pc + 4;
        if (!IF_ID_Stall && !IF_ID_Flush && fetched == HALT) m_halt_pending = 1'b1;
      end else if (m_halt_pending && !IF_ID_Stall) begin
        m_halt_pending = 1'b0;
        if (IF_ID_Flush) m_pc = Redirect_Target;
        else m_halted = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_addr",    IMem_Addr,              m_pc);
      chk("m_instr",   IF_ID_Instr,            m_instr);
      chk("m_pcplus4", IF_ID_PCPlus4,          m_pcp4);
      chk("m_valid",   32'(IF_ID_Valid),       32'(m_valid));
      chk("m_op",      32'(IF_ID_OP),          32'(m_instr[31:26]));
      chk("m_funct",   32'(IF_ID_Funct),       32'(m_instr[5:0]));
      chk("m_rs",      32'(IF_ID_RS),          32'(m_instr[25:21]));
      chk("m_rt",      32'(IF_ID_RT),          32'(m_instr[20:16]));
      chk("m_invrt",   32'(IF_ID_invalidRt),   32'(exp_invalid_rt(m_valid, m_instr)));
      chk("m_halted",  32'(Halted),            32'(m_halted));
      chk("m_stalls",  Stall_Count,            m_stalls);
    end
  end

  task automatic drive(input logic ps, input logic is, input logic fl, input logic [31:0] tgt);
    PC_Stall = ps; IF_ID_Stall = is; IF_ID_Flush = fl; Redirect_Target = tgt;
  endtask

  task automatic edge_and_settle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = FILL;
    mem[0]   = 32'h2008_0005;  // addi $8,$0,5
    mem[1]   = 32'h1109_0003;  // beq
    mem[2]   = 32'h8d2a_0000;  // lw
    mem[3]   = 32'h0100_0008;  // jr $8
    mem[4]   = 32'hac0a_0004;  // sw
    mem[5]   = 32'h0c00_0010;  // jal
    mem[15]  = 32'h3c0b_1234;  // lui
    mem[18]  = HALT;
    mem[511] = 32'h0800_0000;  // j

    RST_N = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1 RST_N = 1'b0;
    #1;
    chk("rst_addr",  IMem_Addr, 32'h0);
    chk("rst_instr", IF_ID_Instr, 32'h0);
    chk("rst_valid", 32'(IF_ID_Valid), 32'h0);
    chk("rst_invrt", 32'(IF_ID_invalidRt), 32'h1);
    chk("rst_stall", Stall_Count, 32'h0);

    @(negedge CLK); RST_N = 1'b1; cmp_en = 1'b1;
    edge_and_settle(1);
    chk("first_instr", IF_ID_Instr, 32'h2008_0005);
    chk("first_pcp4",  IF_ID_PCPlus4, 32'h4);
    chk("first_valid", 32'(IF_ID_Valid), 32'h1);
    chk("first_op",    32'(IF_ID_OP), 32'h8);
    chk("first_rt",    32'(IF_ID_RT), 32'h8);
    chk("first_invrt", 32'(IF_ID_invalidRt), 32'h1);
    chk("first_addr",  IMem_Addr, 32'h4);

    edge_and_settle(3);
    @(negedge CLK); drive(1'b1, 1'b1, 1'b0, 32'h0);
    edge_and_settle(3);
    chk("stall_addr",  IMem_Addr, 32'h10);
    chk("stall_instr", IF_ID_Instr, 32'h0100_0008);
    chk("stall_pcp4",  IF_ID_PCPlus4, 32'h10);
    chk("stall_cnt",   Stall_Count, 32'd3);

    @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 32'h0);
    edge_and_settle(4);
    chk("pre_flush_addr", IMem_Addr, 32'h20);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 32'h400);
    edge_and_settle(1);
    chk("flush_addr",  IMem_Addr, 32'h400);
    chk("flush_instr", IF_ID_Instr, 32'h0);
    chk("flush_valid", 32'(IF_ID_Valid), 32'h0);
    chk("flush_invrt", 32'(IF_ID_invalidRt), 32'h1);

    @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 32'h3C);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge CLK); drive(1'b1, 1'b1, 1'b1, 32'h80);
    edge_and_settle(1);
    chk("sf_addr",  IMem_Addr, 32'h40);
    chk("sf_instr", IF_ID_Instr, 32'h3c0b_1234);
    chk("sf_pcp4",  IF_ID_PCPlus4, 32'h40);
    chk("sf_cnt",   Stall_Count, 32'd4);

    @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 32'h0);
    edge_and_settle(3);
    chk("halt_instr",  IF_ID_Instr, HALT);
    chk("halt_drain",  32'(Halted), 32'h0);
    edge_and_settle(1);
    chk("halted",      32'(Halted), 32'h1);
    chk("halt_valid",  32'(IF_ID_Valid), 32'h0);
    chk("halt_addr",   IMem_Addr, 32'h4C);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 32'h200);
    edge_and_settle(2);
    chk("halt_flush_addr", IMem_Addr, 32'h4C);
    chk("halt_flush_hlt",  32'(Halted), 32'h1);

    @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 32'h0);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_halted", 32'(Halted), 32'h0);
    chk("arst_addr",   IMem_Addr, 32'h0);
    chk("arst_cnt",    Stall_Count, 32'h0);
    @(negedge CLK); RST_N = 1'b1;

    edge_and_settle(1);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 32'h48);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 32'h0);
    edge_and_settle(1);
    chk("wp_instr", IF_ID_Instr, HALT);
    @(negedge CLK); drive(1'b1, 1'b1, 1'b0, 32'h0);
    edge_and_settle(1);
    chk("wp_hold_addr",  IMem_Addr, 32'h4C);
    chk("wp_hold_instr", IF_ID_Instr, HALT);
    chk("wp_hold_cnt",   Stall_Count, 32'h0);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 32'h100);
    edge_and_settle(1);
    chk("wp_halted", 32'(Halted), 32'h0);
    chk("wp_addr",   IMem_Addr, 32'h100);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 32'h0);
    edge_and_settle(1);
    chk("wp_resume_instr", IF_ID_Instr, FILL);
    chk("wp_resume_pcp4",  IF_ID_PCPlus4, 32'h104);
    chk("wp_resume_addr",  IMem_Addr, 32'h104);

    @(negedge CLK); drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    @(negedge CLK); drive(1'b0, 1'b0, 1'b0, 32'h0);
    edge_and_settle(1);
    chk("wrap_addr",  IMem_Addr, 32'h0);
    chk("wrap_pcp4",  IF_ID_PCPlus4, 32'h0);
    chk("wrap_instr", IF_ID_Instr, 32'h0800_0000);
    chk("wrap_invrt", 32'(IF_ID_invalidRt), 32'h1);

    edge_and_settle(3);
    @(negedge CLK); cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
- Consumes the hazard-detection controls PC_Stall, IF_ID_Stall and IF_ID_Flush, together with the redirect target computed in ID.
- Presents the latched instruction and its pre-decoded fields (OP, Funct, RS, RT, invalidRt) to ID and to hazard detection.
- Implements the halt-drain state machine and a stall-cycle performance counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- NOP_WORD, 32'h0000_0000, bubble inserted into IF/ID (sll $0,$0,0).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PC_Stall  in  1  hold PC.
- IF_ID_Stall  in  1  hold IF/ID register.
- IF_ID_Flush  in  1  squash IF/ID and redirect PC.
- Redirect_Target  in  32  jump/branch/jr target from ID; used when IF_ID_Flush=1.
- IMem_Addr  out  32  current PC, to instruction memory (combinational read).
- IMem_Data  in  32  instruction at IMem_Addr, same cycle.
- IF_ID_Instr  out  32  latched instruction.
- IF_ID_PCPlus4  out  32  latched PC+4.
- IF_ID_Valid  out  1  0 = bubble.
- IF_ID_OP  out  6  IF_ID_Instr[31:26].
- IF_ID_Funct  out  6  IF_ID_Instr[5:0].
- IF_ID_RS  out  5  IF_ID_Instr[25:21].
- IF_ID_RT  out  5  IF_ID_Instr[20:16].
- IF_ID_invalidRt  out  1  rt is not a source operand of IF_ID_Instr.
- Halted  out  1  fetch permanently stopped.
- Stall_Count  out  32  number of cycles with PC_Stall=1, saturating.

Behaviour:
- Reset (async, RST_N=0):
  - PC=RESET_PC; IF_ID_Instr=NOP_WORD; IF_ID_PCPlus4=0; IF_ID_Valid=0.
  - State=RUN; Halted=0; Stall_Count=0.
  - Reset applied mid-operation discards all state, including DRAIN and HALTED.
- PC update per edge, priority order:
  1. PC_Stall=1 or state!=RUN: PC holds.
  2. IF_ID_Flush=1: PC<=Redirect_Target.
  3. Otherwise: PC<=PC+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- PC_Stall and IF_ID_Flush both asserted: stall wins, PC holds and the flush is ignored that cycle. Hazard detection re-evaluates next cycle.
- IF/ID update per edge, priority order:
  1. IF_ID_Stall=1: hold all fields.
  2. IF_ID_Flush=1: Instr<=NOP_WORD, Valid<=0, PCPlus4<=0.
  3. state!=RUN: load bubble.
  4. Otherwise: Instr<=IMem_Data, PCPlus4<=PC+4, Valid<=1.
- Fetch latency: the instruction at PC appears on IF_ID_* one edge after PC is presented.
- Decoded outputs are combinational from IF_ID_Instr. Decode of a bubble gives OP=0, Funct=0, RS=0, RT=0.
- IF_ID_invalidRt=1 when IF_ID_Valid=0, or OP is one of:
  - 6'h02 (J) or 6'h03 (JAL);
  - 6'h08..6'h0F (I-type ALU, LUI);
  - 6'h20..6'h25 (loads);
  - 6'h00 with Funct=6'h08 (JR).
- IF_ID_invalidRt=0 for BEQ, BNE, SW and all other R-type instructions.
- State machine:
  - RUN -> DRAIN: on an edge where IF/ID loads HALT_WORD.
  - DRAIN: PC frozen.
    - IF_ID_Flush=1 and IF_ID_Stall=0: the halt was wrong-path; go to RUN and load PC<=Redirect_Target.
    - IF_ID_Stall=0 and no flush: the halt advances to ID; IF/ID loads a bubble; go to HALTED.
    - IF_ID_Stall=1: remain in DRAIN.
  - HALTED: terminal until reset. Halted=1, PC frozen, IF/ID holds bubbles, Flush is ignored for PC.
- Stall_Count increments on each edge with PC_Stall=1 and state=RUN. It saturates at 32'hFFFF_FFFF.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants R_TYPE, J, JAL, BEQ, BNE, LW, SW, ADDI..LUI;
  - funct constant JR;
  - NOP_WORD, HALT_WORD;
  - fetch-state enum RUN/DRAIN/HALTED.
- One sub-module, rt_use_decode: combinational opcode/funct -> invalidRt. It is reused by ID.
- The PC register, IF/ID register, FSM and counter all stay in fetch_stage.

Test Plan:
- Reset release, IMem returns 32'h2008_0005 at PC 0 -> after 1 edge IF_ID_Instr=32'h2008_0005, PCPlus4=4, Valid=1, OP=6'h08, RT=8, invalidRt=1; IMem_Addr=4.
- PC_Stall=IF_ID_Stall=1 for 3 cycles at PC=0x10 -> IMem_Addr stays 0x10, IF/ID fields unchanged, Stall_Count=3.
- IF_ID_Flush=1 with Redirect_Target=0x400 at PC=0x20 -> next edge IMem_Addr=0x400, IF_ID_Instr=0, Valid=0, invalidRt=1.
- PC_Stall=1 and IF_ID_Flush=1 together, Redirect_Target=0x80, PC=0x40 -> PC stays 0x40, IF/ID held.
- HALT_WORD fetched, no stalls -> DRAIN for 1 cycle, then Halted=1. PC frozen at halt address+4; IF_ID_Valid=0 thereafter; later IF_ID_Flush leaves PC unchanged.
- HALT_WORD in IF/ID then IF_ID_Flush=1, Redirect_Target=0x100 -> state RUN, Halted=0, IMem_Addr=0x100, fetch resumes. Also assert RST_N=0 while in HALTED -> Halted=0, PC=RESET_PC immediately, without waiting for a clock edge.
